status_frame_tx: RTL and testbench
==================================

STATUS_FRAME_TX -- requirements
Module: status_frame_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal minimum 2.
REQ-002 SHALL have parameter HEARTBEAT_CYC, default 4096: cycles between unconditional status frames; SHALL exceed 12*CLKS_PER_BIT.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port display, input, 3 bits: controller state code.
REQ-006 SHALL have ports fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler, each input, 1 bit: controller actuator flags.
REQ-007 SHALL have port tx, output, 1 bit: serial status line to the panel; idles high.
REQ-008 SHALL have port busy, output, 1 bit: high while a frame is on tx.
REQ-009 SHALL have port drop_cnt, output, 8 bits: count of status values overwritten before transmission.

Function
REQ-010 SHALL register the 9-bit snapshot S = {cooler, heater, alarmbuzz, winbuzz, rdoor, fdoor, display[2:0]} every cycle; S[0] is display[0].
REQ-011 SHALL hold last_sent, the S value of the most recent frame, plus a sent_valid flag.
REQ-012 Frame format SHALL be 12 bits, each CLKS_PER_BIT cycles: start bit 0, S[0]..S[8] LSB first, even-parity bit (total ones over S and parity is even), stop bit 1.
REQ-013 While idle, a frame SHALL start on the edge after S differs from last_sent, or sent_valid=0, or a heartbeat is pending.
REQ-014 Latency: an input change present before edge k SHALL drive tx low at edge k+1 when idle.
REQ-015 At frame start, the block SHALL copy S into the shift register and last_sent, set sent_valid=1, set busy=1, and clear the heartbeat counter and heartbeat request.
REQ-016 Input changes during a frame SHALL NOT alter the frame in flight.
REQ-017 busy SHALL fall on the edge that ends the stop bit; tx SHALL stay high for at least one cycle before the next start bit.
REQ-018 Only the latest S SHALL be sent after a frame; intermediate values are discarded.
REQ-019 drop_cnt SHALL increment on each edge where busy=1, S changes value, and the pre-change S differed from last_sent.
REQ-020 drop_cnt SHALL saturate at 255.
REQ-021 If S returns to last_sent before the block goes idle, no extra frame SHALL be sent.
REQ-022 The heartbeat counter SHALL count every cycle since the last frame start.
REQ-023 At HEARTBEAT_CYC-1 the counter SHALL set the heartbeat request; the request is held through busy and served when idle.
REQ-024 A change-triggered frame and a heartbeat due in the same cycle SHALL produce exactly one frame.
REQ-025 No state encoding of display SHALL be interpreted; all 8 codes are forwarded verbatim.

Reset
REQ-026 While Rst=1 at an edge: tx=1, busy=0, drop_cnt=0, sent_valid=0, heartbeat counter=0, bit and baud counters=0, last_sent=0.
REQ-027 Rst asserted mid-frame SHALL abort the frame; tx=1 from the next edge.
REQ-028 After release, the first frame SHALL be a power-up report of the current S, whatever its value.

Verification (CLKS_PER_BIT=4, HEARTBEAT_CYC=256)
REQ-029 Scenario: Rst=1 for 3 cycles, all inputs 0, then release.
  Required: tx=1, busy=0 and drop_cnt=0 during reset.
  Required: tx low 1 edge after release.
  Required: bit sequence 0, nine 0s, parity 0, stop 1; busy high exactly 48 cycles.
REQ-030 Scenario: idle with last_sent=0, apply display=011 and alarmbuzz=1.
  Required: data bits 1,1,0,0,0,0,1,0,0; parity 1; tx start 2 edges after the input change.
REQ-031 Scenario: during a frame, S changes A->B then B->C, with A the value being sent.
  Required: drop_cnt=1.
  Required: next frame carries C, starting 2 edges after busy falls.
REQ-032 Scenario: during a frame, S changes A->B then back to A.
  Required: drop_cnt increments by 1; no further frame until the heartbeat.
REQ-033 Scenario: inputs stable after a frame.
  Required: heartbeat frame starts exactly 256 cycles after the previous start, carrying the unchanged S.
REQ-034 Scenario: Rst=1 for 1 cycle at bit 5 of a frame.
  Required: tx=1 and busy=0 next edge; drop_cnt=0; power-up frame follows release.

Source files
------------

// File: rtl/status_frame_tx.sv
// Serialises a 9-bit controller status snapshot onto a UART-like line whenever it
// changes, after reset, or on a periodic heartbeat; counts values lost to overwrite.
module status_frame_tx #(
  parameter int CLKS_PER_BIT  = 16,
  parameter int HEARTBEAT_CYC = 4096
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic [2:0] display,
  input  logic       fdoor,
  input  logic       rdoor,
  input  logic       winbuzz,
  input  logic       alarmbuzz,
  input  logic       heater,
  input  logic       cooler,
  output logic       tx,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam int BW  = $clog2(CLKS_PER_BIT);
  localparam int HBW = $clog2(HEARTBEAT_CYC);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [HBW-1:0] HB_LAST   = HBW'(HEARTBEAT_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_GAP} state_t;

  state_t          state_q, state_d;
  logic [8:0]      s_q, s_d;
  logic [8:0]      last_sent_q, last_sent_d;
  logic            sent_valid_q, sent_valid_d;
  logic [10:0]     shift_q, shift_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [3:0]      bit_q, bit_d;
  logic            tx_q, tx_d;
  logic [7:0]      drop_q, drop_d;
  logic [HBW-1:0]  hb_cnt_q, hb_cnt_d;
  logic            hb_req_q, hb_req_d;
  logic            start;

  function automatic logic even_parity(input logic [8:0] v);
    return ^v;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d      = state_q;
    s_d          = {cooler, heater, alarmbuzz, winbuzz, rdoor, fdoor, display};
    last_sent_d  = last_sent_q;
    sent_valid_d = sent_valid_q;
    shift_d      = shift_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    tx_d         = tx_q;
    drop_d       = drop_q;
    hb_cnt_d     = hb_cnt_q;
    hb_req_d     = hb_req_q;
    start        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((s_q != last_sent_q) || !sent_valid_q || hb_req_q || (hb_cnt_q == HB_LAST))
          start = 1'b1;
      end
      ST_BUSY: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 4'd11) begin
            // End of stop bit: one forced idle cycle follows before any new start bit.
            state_d = ST_GAP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 4'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b1, shift_q[10:1]};
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d      = ST_BUSY;
      shift_d      = {1'b1, even_parity(s_q), s_q};
      last_sent_d  = s_q;
      sent_valid_d = 1'b1;
      tx_d         = 1'b0;
      baud_d       = '0;
      bit_d        = '0;
      hb_cnt_d     = '0;
      hb_req_d     = 1'b0;
    end else if (hb_cnt_q == HB_LAST) begin
      hb_req_d = 1'b1;
    end else begin
      hb_cnt_d = hb_cnt_q + 1'b1;
    end

    // A value is lost only if it was itself unsent when the snapshot moves on.
    if ((state_q == ST_BUSY) && (s_d != s_q) && (s_q != last_sent_q))
      drop_d = sat_inc(drop_q);
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      last_sent_q  <= '0;
      sent_valid_q <= 1'b0;
      baud_q       <= '0;
      bit_q        <= '0;
      tx_q         <= 1'b1;
      drop_q       <= '0;
      hb_cnt_q     <= '0;
      hb_req_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_sent_q  <= last_sent_d;
      sent_valid_q <= sent_valid_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      tx_q         <= tx_d;
      drop_q       <= drop_d;
      hb_cnt_q     <= hb_cnt_d;
      hb_req_q     <= hb_req_d;
    end
  end

  always_ff @(posedge clk) begin
    s_q     <= s_d;
    shift_q <= shift_d;
  end

  assign tx       = tx_q;
  assign busy     = (state_q == ST_BUSY);
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_status_frame_tx.sv
// Directed bench for status_frame_tx: frame format, latency, drop counting,
// heartbeat timing and mid-frame reset, with CLKS_PER_BIT=4 and HEARTBEAT_CYC=256.
module tb_status_frame_tx;

  logic       clk = 1'b0;
  logic       Rst;
  logic [2:0] display;
  logic       fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler;
  logic       tx, busy;
  logic [7:0] drop_cnt;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [8:0] s;
    logic       par;
  } vec_t;

  vec_t vecs [6];

  status_frame_tx #(.CLKS_PER_BIT(4), .HEARTBEAT_CYC(256)) dut (
    .clk(clk), .Rst(Rst), .display(display), .fdoor(fdoor), .rdoor(rdoor),
    .winbuzz(winbuzz), .alarmbuzz(alarmbuzz), .heater(heater), .cooler(cooler),
    .tx(tx), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_s(input logic [8:0] v);
    {cooler, heater, alarmbuzz, winbuzz, rdoor, fdoor, display} = v;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called just after the start-bit edge; samples each bit mid-cell.
  task automatic rx_frame(input string nm, input logic [8:0] exp_s, input logic exp_par,
                          input logic do_chg, input logic [8:0] ca, input logic [8:0] cb);
    logic [11:0] got;
    logic [11:0] exp;
    int bc;
    got = '0;
    bc  = 0;
    for (int c = 0; c < 48; c++) begin
      if (c % 4 == 2) got[c/4] = tx;
      if (busy) bc++;
      if (do_chg && c == 10) set_s(ca);
      if (do_chg && c == 20) set_s(cb);
      tick();
    end
    exp = {1'b1, exp_par, exp_s, 1'b0};
    chk({nm, " frame bits"}, 32'(got), 32'(exp));
    chk({nm, " busy cycles"}, bc, 48);
    chk({nm, " busy low after stop"}, 32'(busy), 0);
    chk({nm, " tx idle after stop"}, 32'(tx), 1);
  endtask

  initial begin
    int start_cyc;
    int waited;

    vecs[0] = '{9'b001000011, 1'b1};
    vecs[1] = '{9'b111111111, 1'b1};
    vecs[2] = '{9'b110000000, 1'b0};
    vecs[3] = '{9'b010101010, 1'b0};
    vecs[4] = '{9'b100000000, 1'b1};
    vecs[5] = '{9'b000000101, 1'b0};

    // Reset with all inputs low, then power-up frame of zeros.
    Rst = 1'b1;
    set_s(9'h000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset tx", 32'(tx), 1);
      chk("reset busy", 32'(busy), 0);
      chk("reset drop_cnt", 32'(drop_cnt), 0);
    end
    Rst = 1'b0;
    tick();
    chk("powerup start tx", 32'(tx), 0);
    chk("powerup start busy", 32'(busy), 1);
    rx_frame("powerup", 9'h000, 1'b0, 1'b0, 9'h0, 9'h0);

    // Table of change-triggered frames: latency of two edges, then contents.
    for (int i = 0; i < 6; i++) begin
      set_s(vecs[i].s);
      tick();
      chk($sformatf("vec%0d tx before start", i), 32'(tx), 1);
      tick();
      chk($sformatf("vec%0d start bit", i), 32'(tx), 0);
      rx_frame($sformatf("vec%0d", i), vecs[i].s, vecs[i].par, 1'b0, 9'h0, 9'h0);
    end

    // A sent, A->B->C during the frame: one drop, C follows after the gap.
    set_s(9'h1C3);
    tick();
    tick();
    chk("A start bit", 32'(tx), 0);
    rx_frame("A", 9'h1C3, 1'b1, 1'b1, 9'h0F0, 9'h033);
    chk("drop after A->B->C", 32'(drop_cnt), 1);
    tick();
    chk("gap after busy falls", 32'(tx), 1);
    tick();
    chk("C start bit", 32'(tx), 0);
    rx_frame("C", 9'h033, 1'b0, 1'b0, 9'h0, 9'h0);

    // D sent, D->E->D during the frame: one drop, then only the heartbeat.
    set_s(9'h155);
    tick();
    tick();
    chk("D start bit", 32'(tx), 0);
    start_cyc = cyc;
    rx_frame("D", 9'h155, 1'b1, 1'b1, 9'h000, 9'h155);
    chk("drop after D->E->D", 32'(drop_cnt), 2);
    waited = 0;
    while (tx !== 1'b0 && waited < 300) begin
      tick();
      waited++;
    end
    chk("heartbeat start offset", cyc - start_cyc, 256);
    rx_frame("heartbeat", 9'h155, 1'b1, 1'b0, 9'h0, 9'h0);

    // Reset during bit 5 of a frame aborts it; power-up frame follows.
    set_s(9'h0AA);
    tick();
    tick();
    chk("F start bit", 32'(tx), 0);
    for (int i = 0; i < 21; i++) tick();
    chk("F mid-frame busy", 32'(busy), 1);
    Rst = 1'b1;
    tick();
    chk("abort tx", 32'(tx), 1);
    chk("abort busy", 32'(busy), 0);
    chk("abort drop_cnt", 32'(drop_cnt), 0);
    Rst = 1'b0;
    tick();
    chk("post-abort start bit", 32'(tx), 0);
    rx_frame("post-abort", 9'h0AA, 1'b0, 1'b0, 9'h0, 9'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
